uart_rx_oversampler: RTL and testbench
======================================

// Module: uart_rx_oversampler
// PURPOSE
//  UART receiver for the CPU's peripheral bus. Samples serial line rx at 16x baud using sam_clk from the baud-rate generator.
//  Frame format is 8N1, LSB first; each received byte is presented in a one-byte holding register.
//  Also reports framing and overrun errors to the CPU UART control logic.
// PARAMETERS
//  OVERSAMPLE  16  sam_clk cycles per bit; even, >=8
//  DATA_BITS   8   data bits per frame
// PORTS
//  sam_clk   input   1          16x-baud sample clock
//  reset     input   1          asynchronous, active-low reset
//  rx        input   1          serial line, idle high, asynchronous to sam_clk
//  rx_ack    input   1          consumer has taken rx_data (1-cycle pulse)
//  rx_data   output  DATA_BITS  holding register, last good byte
//  rx_valid  output  1          holding register full; level
//  frame_err output  1          1-cycle pulse on bad stop bit
//  overrun   output  1          sticky: byte lost because holding register was full
//  busy      output  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; rx_data=0; synchronizer flops=1; state=IDLE.
//  rx passes through a 2-flop synchronizer (rx_s). Every decision below uses rx_s only.
//  Counters:
//   - cnt: 0..OVERSAMPLE-1, cleared on every state change.
//   - bitn: 0..DATA_BITS-1.
//  State machine:
//   IDLE:   rx_s==0 -> START, cnt=0.
//   START:  at cnt==OVERSAMPLE/2-1 (mid start bit):
//           - rx_s==0 -> DATA, cnt=0, bitn=0.
//           - rx_s==1 -> IDLE (glitch rejected; no error reported).
//   DATA:   at cnt==OVERSAMPLE-1, shift in rx_s at position bitn (LSB first).
//           When bitn==DATA_BITS-1 -> STOP; otherwise bitn++.
//   STOP:   at cnt==OVERSAMPLE-1 (mid stop bit):
//           - rx_s==1 -> deliver the byte (see Delivery), then IDLE.
//           - rx_s==0 -> frame_err=1 for one cycle, byte discarded, then BREAK.
//   BREAK:  wait for rx_s==1, then IDLE. A held-low line therefore never retriggers a frame.
//  Delivery (cycle after the stop-bit sample):
//   - rx_valid==0, or rx_ack in the same cycle: rx_data<=byte, rx_valid<=1.
//   - rx_valid==1 and no rx_ack: new byte dropped, rx_data unchanged, overrun<=1.
//  rx_ack:
//   - Clears rx_valid the next cycle unless a new byte loads in that same cycle.
//   - Clears overrun.
//   - Ignored when rx_valid==0.
//  Latency: rx_valid rises 2 + OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE + 1 sam_clk after the rx falling edge (+/-1).
//   With defaults this is 155 cycles.
//  Next start edge is accepted from IDLE immediately after the stop sample, so back-to-back frames are supported.
//  Reset asserted mid-frame: immediate return to reset values; the partial byte is lost.
//   After reset releases, the next frame with a valid start bit is received correctly.
//  Baud tolerance: the mid-bit sampling point tolerates +/-3% baud mismatch over the 10-bit frame.
// TESTING
//  1. Frames 0x24 then 0x30, 16 sam_clk/bit, 10-bit idle gap, rx_ack ~5 cycles after each rx_valid
//     -> rx_data=0x24 then 0x30; rx_valid high once per byte; no errors.
//  2. rx low for 4 sam_clk, then high -> busy pulses, returns to IDLE; rx_valid, frame_err, overrun stay 0.
//  3. Frame 0xA5 with stop bit 0, line then held low 40 bit-times, then 0x5A sent
//     -> one frame_err pulse; no rx_valid for 0xA5; rx_data=0x5A afterward.
//  4. Frames 0x11 and 0x22 without rx_ack -> rx_data=0x11, rx_valid=1, overrun=1.
//     Then rx_ack -> rx_valid=0, overrun=0.
//  5. rx_ack asserted in the exact cycle a second byte 0x33 is delivered
//     -> rx_data=0x33, rx_valid stays 1, overrun=0.
//  6. reset pulled low during data bit 4 of 0xFF, then 0x81 sent
//     -> outputs 0 during reset; rx_data=0x81 afterward, with no spurious byte.

Source files
------------

// File: rtl/uart_rx_oversampler.sv
// uart_rx_oversampler: 8N1 UART receiver sampled at OVERSAMPLE x baud, one-byte holding register with framing/overrun flags.
module uart_rx_oversampler #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 sam_clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
    state_t               state_q;
    logic                 rx_meta_q, rx_s_q, deliver_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bitn_q;
    logic [DATA_BITS-1:0] shift_q, rx_data_q;
    logic                 rx_valid_q, frame_err_q, overrun_q, busy_q;
    logic                 mid, last;
    assign mid       = cnt_q == CW'(OVERSAMPLE / 2 - 1);
    assign last      = cnt_q == CW'(OVERSAMPLE - 1);
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;
    always_ff @(posedge sam_clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitn_q      <= '0;
            shift_q     <= '0;
            deliver_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            deliver_q   <= 1'b0;
            frame_err_q <= 1'b0;
            cnt_q       <= cnt_q + CW'(1);
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: if (mid) begin
                    cnt_q   <= '0;
                    bitn_q  <= '0;
                    state_q <= rx_s_q ? IDLE : DATA;
                    busy_q  <= !rx_s_q;
                end
                DATA: if (last) begin
                    cnt_q           <= '0;
                    shift_q[bitn_q] <= rx_s_q;
                    if (bitn_q == BW'(DATA_BITS - 1))
                        state_q <= STOP;
                    else
                        bitn_q <= bitn_q + BW'(1);
                end
                STOP: if (last) begin
                    cnt_q       <= '0;
                    deliver_q   <= rx_s_q;
                    frame_err_q <= !rx_s_q;
                    state_q     <= rx_s_q ? IDLE : BRK;
                    busy_q      <= !rx_s_q;
                end
                default: begin
                    // line held low after a bad stop bit must not start a new frame
                    cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
            if (deliver_q && (!rx_valid_q || rx_ack)) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
            end else if (rx_ack) begin
                rx_valid_q <= 1'b0;
            end
            if (deliver_q && rx_valid_q && !rx_ack)
                overrun_q <= 1'b1;
            else if (rx_ack && rx_valid_q)
                overrun_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_oversampler.sv
// tb_uart_rx_oversampler: directed frame table plus hand-timed corner sequences for uart_rx_oversampler.
module tb_uart_rx_oversampler;
    logic       sam_clk = 1'b0;
    logic       reset   = 1'b0;
    logic       rx      = 1'b1;
    logic       rx_ack  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;
    int         tests = 0;
    int         fails = 0;
    int         ferr_cnt = 0;
    int         vrise_cnt = 0;
    logic       valid_prev = 1'b0;
    logic       busy_seen = 1'b0;

    uart_rx_oversampler dut (
        .sam_clk  (sam_clk),
        .reset    (reset),
        .rx       (rx),
        .rx_ack   (rx_ack),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 sam_clk = ~sam_clk;

    always @(negedge sam_clk) begin
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (rx_valid && !valid_prev) vrise_cnt <= vrise_cnt + 1;
        valid_prev <= rx_valid;
        if (busy) busy_seen <= 1'b1;
    end

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_ov;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sam_clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(16);
        end
        rx = stop;
        tick(16);
    endtask

    task automatic do_ack();
        tick(5);
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        tick(1);
    endtask

    initial begin
        int ferr0, vr0;
        vecs[0] = '{8'h24, 1'b1, 8'h24, 1'b1, 1'b0};
        vecs[1] = '{8'h30, 1'b1, 8'h30, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 8'h80, 1'b1, 1'b0};
        vecs[4] = '{8'h11, 1'b0, 8'h11, 1'b1, 1'b0};
        vecs[5] = '{8'h22, 1'b1, 8'h11, 1'b1, 1'b1};

        @(posedge sam_clk);
        #1;
        tick(3);
        check("reset rx_data", rx_data, 0);
        check("reset rx_valid", rx_valid, 0);
        check("reset frame_err", frame_err, 0);
        check("reset overrun", overrun, 0);
        check("reset busy", busy, 0);
        reset = 1'b1;
        tick(20);

        for (int i = 0; i < 6; i++) begin
            ferr0 = ferr_cnt;
            send_frame(vecs[i].data, 1'b1);
            check($sformatf("vec%0d rx_data", i), rx_data, vecs[i].exp_data);
            check($sformatf("vec%0d rx_valid", i), rx_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d overrun", i), overrun, vecs[i].exp_ov);
            check($sformatf("vec%0d frame_err", i), ferr_cnt - ferr0, 0);
            if (vecs[i].ack) begin
                do_ack();
                check($sformatf("vec%0d valid after ack", i), rx_valid, 0);
                check($sformatf("vec%0d overrun after ack", i), overrun, 0);
            end
            tick(150);
        end

        // glitch on the start bit
        ferr0 = ferr_cnt;
        vr0 = vrise_cnt;
        busy_seen = 1'b0;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(30);
        check("glitch busy seen", busy_seen, 1);
        check("glitch busy end", busy, 0);
        check("glitch no valid", vrise_cnt - vr0, 0);
        check("glitch no frame_err", ferr_cnt - ferr0, 0);
        check("glitch no overrun", overrun, 0);

        // bad stop bit followed by a long break
        ferr0 = ferr_cnt;
        vr0 = vrise_cnt;
        send_frame(8'hA5, 1'b0);
        tick(40 * 16);
        check("break busy", busy, 1);
        check("break no valid", rx_valid, 0);
        check("break frame_err pulses", ferr_cnt - ferr0, 1);
        rx = 1'b1;
        tick(16);
        check("break released busy", busy, 0);
        send_frame(8'h5A, 1'b1);
        check("after break rx_data", rx_data, 8'h5A);
        check("after break rx_valid", rx_valid, 1);
        check("after break valid rises", vrise_cnt - vr0, 1);
        check("after break frame_err pulses", ferr_cnt - ferr0, 1);
        do_ack();
        tick(150);

        // ack coincides with delivery of the next byte
        send_frame(8'h44, 1'b1);
        tick(160);
        check("pre-coincide rx_data", rx_data, 8'h44);
        fork
            send_frame(8'h33, 1'b1);
            begin
                repeat (155) @(posedge sam_clk);
                #1 rx_ack = 1'b1;
                @(posedge sam_clk);
                #1 rx_ack = 1'b0;
            end
        join
        check("coincide rx_data", rx_data, 8'h33);
        check("coincide rx_valid", rx_valid, 1);
        check("coincide overrun", overrun, 0);
        do_ack();
        check("coincide valid after ack", rx_valid, 0);
        tick(160);

        // reset mid-frame
        vr0 = vrise_cnt;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                tick(85);
                reset = 1'b0;
                tick(2);
                check("midreset rx_data", rx_data, 0);
                check("midreset rx_valid", rx_valid, 0);
                check("midreset busy", busy, 0);
                check("midreset overrun", overrun, 0);
                check("midreset frame_err", frame_err, 0);
                reset = 1'b1;
            end
        join
        tick(160);
        send_frame(8'h81, 1'b1);
        check("post-reset rx_data", rx_data, 8'h81);
        check("post-reset rx_valid", rx_valid, 1);
        check("post-reset single byte", vrise_cnt - vr0, 1);
        do_ack();
        tick(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
